fnd_scan_controller: RTL
========================

// Module: fnd_scan_controller
// PURPOSE
//  Sequences the 4-digit FND (7-segment) display for the 0-9999 counter system.
//  Captures a binary value, converts it to BCD with a sequential shift-add-3 engine,
//  and time-multiplexes the four digits through a prescaled 2-bit digit-select counter.
//  Sits between the value source (counter/UI logic) and the FND pins.
// PARAMETERS
//  SCAN_DIV   100_000  clocks per digit slot (100 MHz -> 1 kHz digit rate); min 2
// PORTS
//  i_clk        in   1   system clock; all logic on posedge
//  i_reset      in   1   synchronous, active-high reset
//  i_value      in   14  binary value to display
//  i_load       in   1   1-cycle strobe: capture i_value and start conversion
//  i_blank_lz   in   1   1 = blank leading zeros (digit 0 always shown)
//  o_busy       out  1   1 while conversion in progress
//  o_digit_sel  out  2   current digit index, 0 = ones ... 3 = thousands
//  o_fnd_com    out  4   digit enables, active-low, one-hot
//  o_fnd_font   out  8   segments {dp,g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Reset (i_reset high at posedge, overrides everything incl. i_load):
//   state IDLE, o_busy 0, prescaler 0, o_digit_sel 0, displayed BCD 0000,
//   o_fnd_com 4'b1110, o_fnd_font 8'hC0.
//  FSM: IDLE --(i_load)--> CONV --(14th shift)--> IDLE. o_busy = (state==CONV).
//   - i_load sampled at edge k in IDLE: value captured (clamped to 9999 if >9999),
//     BCD scratch cleared, shift count 13; o_busy high after edge k.
//   - CONV, each cycle: every scratch nibble >=5 gets +3, then {scratch,bin} <<1.
//   - Edge k+14: final BCD committed to display register in one step (all four
//     digits change atomically), state IDLE, o_busy low after that edge.
//   - i_load while CONV is ignored (no queueing, no restart).
//   - Display register holds old digits throughout conversion.
//  Scan: prescaler counts 0..SCAN_DIV-1 continuously, independent of FSM.
//   - At terminal count prescaler -> 0 and o_digit_sel increments; 3 wraps to 0.
//  Outputs registered: o_fnd_com/o_fnd_font reflect the o_digit_sel value one
//   cycle after it changes (1-cycle latency), and reflect a committed BCD update
//   one cycle after the commit edge.
//   - o_fnd_com = ~(4'b0001 << digit); dp bit always 1 (off).
//   - Font (active-low): 0 C0,1 F9,2 A4,3 B0,4 99,5 92,6 82,7 F8,8 80,9 90.
//   - Blanking: digit d (d=1..3) outputs 8'hFF when i_blank_lz=1 and all digits
//     d..3 are zero; i_blank_lz sampled live each cycle. Value 0 shows "0" on digit 0.
//  Reset mid-conversion: conversion aborted, display returns to 0000, o_busy 0.
// TESTING (bench uses SCAN_DIV=4)
//  1 Reset: assert i_reset 2 cycles -> o_busy 0, com 4'b1110, font 8'hC0, sel 0.
//  2 i_load, i_value=1234 -> o_busy high exactly 14 cycles; then digit0..3 fonts
//    99,B0,A4,F9 with com 1110,1101,1011,0111, each slot held 4 cycles, sel wraps 3->0.
//  3 i_value=16383 load -> clamped, all four digits font 8'h90.
//  4 i_value=7, i_blank_lz=1 -> digit0 8'hF8, digits1-3 8'hFF; i_blank_lz=0 -> C0.
//  5 Load 1234, pulse i_load with 5678 at busy cycle 5 -> ignored, result 1234, busy 14 cycles.
//  6 Load 9999, assert i_reset at busy cycle 7 -> o_busy 0, display 0000, font C0.

Source files
------------

// File: rtl/fnd_scan_controller.sv
// 4-digit 7-segment scan controller: binary capture, sequential double-dabble BCD, prescaled digit mux.
// Conversion takes 14 cycles after load; segment/common outputs lag digit_sel by one cycle.
module fnd_scan_controller #(
    parameter int SCAN_DIV = 100_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [13:0] i_value,
    input  logic        i_load,
    input  logic        i_blank_lz,
    output logic        o_busy,
    output logic [1:0]  o_digit_sel,
    output logic [3:0]  o_fnd_com,
    output logic [7:0]  o_fnd_font
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {IDLE, CONV} state_t;

    state_t        state;
    logic [15:0]   scratch;
    logic [13:0]   bin;
    logic [3:0]    shift_cnt;
    logic [15:0]   disp;
    logic [PW-1:0] pre;

    logic [15:0]   adj;
    logic [15:0]   shifted;
    logic [3:0]    cur_digit;
    logic [3:0]    nib_zero;
    logic          blank;

    // Add-3 correction on every nibble that would overflow past 9 after the shift.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        shifted = {adj[14:0], bin[13]};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            o_busy    <= 1'b0;
            scratch   <= '0;
            bin       <= '0;
            shift_cnt <= '0;
            disp      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_load) begin
                        bin       <= (i_value > 14'd9999) ? 14'd9999 : i_value;
                        scratch   <= '0;
                        shift_cnt <= 4'd13;
                        state     <= CONV;
                        o_busy    <= 1'b1;
                    end
                end
                CONV: begin
                    scratch <= shifted;
                    bin     <= {bin[12:0], 1'b0};
                    if (shift_cnt == 4'd0) begin
                        // Commit all four digits at once so the display never shows a partial result.
                        disp   <= shifted;
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        shift_cnt <= shift_cnt - 4'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pre         <= '0;
            o_digit_sel <= 2'd0;
        end else if (pre == PW'(SCAN_DIV - 1)) begin
            pre         <= '0;
            o_digit_sel <= o_digit_sel + 2'd1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 8'hC0;
            4'd1:    seg_of = 8'hF9;
            4'd2:    seg_of = 8'hA4;
            4'd3:    seg_of = 8'hB0;
            4'd4:    seg_of = 8'h99;
            4'd5:    seg_of = 8'h92;
            4'd6:    seg_of = 8'h82;
            4'd7:    seg_of = 8'hF8;
            4'd8:    seg_of = 8'h80;
            4'd9:    seg_of = 8'h90;
            default: seg_of = 8'hFF;
        endcase
    endfunction

    always_comb begin
        cur_digit = disp[4*o_digit_sel +: 4];
        for (int i = 0; i < 4; i++)
            nib_zero[i] = (disp[4*i +: 4] == 4'd0);
        // A digit is a leading zero only if it and every more significant digit are zero.
        case (o_digit_sel)
            2'd3:    blank = i_blank_lz & nib_zero[3];
            2'd2:    blank = i_blank_lz & nib_zero[3] & nib_zero[2];
            2'd1:    blank = i_blank_lz & nib_zero[3] & nib_zero[2] & nib_zero[1];
            default: blank = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_fnd_com  <= 4'b1110;
            o_fnd_font <= 8'hC0;
        end else begin
            o_fnd_com  <= ~(4'b0001 << o_digit_sel);
            o_fnd_font <= blank ? 8'hFF : seg_of(cur_digit);
        end
    end

endmodule
